// File: rtl/count_pkg.sv
// Shared definitions for the counter-consumer slice: count width, duty FSM
// states and the default stall threshold.
package count_pkg;

  localparam int COUNT_W          = 8;
  localparam int STALL_CYCLES_DEF = 16;

  typedef enum logic {
    IDLE,
    PENDING
  } duty_state_e;

endpackage : count_pkg

// File: rtl/stall_detect.sv
// Flags a counter that has not moved for STALL_CYCLES consecutive samples;
// any change in the sampled value clears the run immediately.
module stall_detect
  import count_pkg::*;
#(
  parameter int WIDTH        = COUNT_W,
  parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             primed,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] count_q,
  output logic             stall
);

  localparam int                CNT_W     = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  STALL_MAX = CNT_W'(STALL_CYCLES);

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             stall_d, stall_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stall_cnt_d = '0;
    if (primed && (count == count_q)) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
    // Decoded from the next count so stall drops on the edge that sees the change.
    stall_d = (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign stall = stall_q;

endmodule : stall_detect

// File: rtl/count_pwm.sv
// Turns the free-running counter value into a registered PWM waveform with a
// double-buffered duty, a wrap-around pulse and a stalled-counter flag.
module count_pwm
  import count_pkg::*;
#(
  parameter int               WIDTH        = COUNT_W,
  parameter logic [WIDTH-1:0] DUTY_INIT    = '0,
  parameter int               STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             polarity,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic             stall
);

  logic [WIDTH-1:0] count_d, count_q;
  logic             primed_d, primed_q;
  logic             wrap_d, wrap_pulse_q;
  logic             pwm_d, pwm_q;

  duty_state_e      state_q;
  logic [WIDTH-1:0] shadow_q, active_duty_q;
  logic             duty_ready_q;

  always_comb begin
    count_d  = count;
    primed_d = 1'b1;
    // A drop in value is a wrap, whether rollover or an upstream counter reset.
    wrap_d   = primed_q && (count < count_q);
    pwm_d    = (count < active_duty_q) ^ polarity;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      primed_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      primed_q     <= primed_d;
      wrap_pulse_q <= wrap_d;
      pwm_q        <= pwm_d;
    end
  end

  // Duty hand-off: a write parks in shadow_q and only reaches the comparator on
  // a wrap; a write accepted on a wrap cycle waits for the following wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      active_duty_q <= DUTY_INIT;
      duty_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (duty_valid && duty_ready_q) begin
            shadow_q     <= duty;
            state_q      <= PENDING;
            duty_ready_q <= 1'b0;
          end
        end
        PENDING: begin
          if (wrap_d) begin
            active_duty_q <= shadow_q;
            state_q       <= IDLE;
            duty_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  stall_detect #(
    .WIDTH        (WIDTH),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_stall_detect (
    .clk     (clk),
    .reset   (reset),
    .primed  (primed_q),
    .count   (count),
    .count_q (count_q),
    .stall   (stall)
  );

  assign duty_ready = duty_ready_q;
  assign pwm_out    = pwm_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule : count_pwm
